bist_fail_log: RTL and testbench

- Read-compare and fail-capture stage attached to the memory BIST controller.
- Sits directly downstream of the controller's read/data outputs and the memory's read data.
- Produces the controller's is_equal input.
- Logs every failing read (address, expected bit, optional syndrome) into a small FIFO that diagnostics drain through a valid/ready-style handshake.

---
 rtl/bist_pkg.sv | 48 ++++
 rtl/bist_fail_fifo.sv | 90 +++++++++
 rtl/bist_fail_log.sv | 167 ++++++++++++++++
 tb/tb_bist_fail_log.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//
// Shared constants for the BIST read-compare / fail-capture slice.
//
// Contents:
//   SYN_EN          - 1 when the syndrome field is compiled in
//                     (macro BIST_LOG_SYNDROME_EN), else 0
//   EXP_R0, EXP_R1  - encoding of the expected data bit / march read phase
//   ADDR_LSB        - bit offset of the address field in a log entry
//   exp_bit_pos()   - bit offset of the expected-bit field
//   syn_lsb()       - bit offset of the syndrome field (when present)
//   entry_width()   - total log entry width for a given AW/DW
//   cnt_sat_max()   - saturation value of a CNT_W-bit fail counter
//
// Log entry layout (LSB first): addr[AW-1:0], exp, [syndrome[DW-1:0]]
// -----------------------------------------------------------------------------
package bist_pkg;

`ifdef BIST_LOG_SYNDROME_EN
   localparam bit SYN_EN = 1'b1;
`else
   localparam bit SYN_EN = 1'b0;
`endif

   // Expected data bit doubles as the march phase indicator.
   localparam logic EXP_R0 = 1'b0;
   localparam logic EXP_R1 = 1'b1;

   localparam int ADDR_LSB = 0;

   function automatic int exp_bit_pos(input int aw);
      return aw;
   endfunction

   function automatic int syn_lsb(input int aw);
      return aw + 1;
   endfunction

   function automatic int entry_width(input int aw, input int dw);
      return aw + 1 + (SYN_EN ? dw : 0);
   endfunction

   function automatic longint unsigned cnt_sat_max(input int cnt_w);
      return (64'd1 << cnt_w) - 64'd1;
   endfunction

endpackage

// File: rtl/bist_fail_fifo.sv
// -----------------------------------------------------------------------------
// bist_fail_fifo
//
// Small synchronous FIFO holding fail-log entries.
//
// Parameters:
//   W      - entry width
//   DEPTH  - number of entries, power of two, >= 2
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst    in   asynchronous active-high reset (empties FIFO, clears storage)
//   clr    in   synchronous clear, highest priority (empties FIFO)
//   push   in   write din at the tail (accepted if not full, or if a pop
//               happens in the same cycle)
//   din    in   W     entry to write
//   pop    in   advance the head (ignored when empty)
//   dout   out  W     head entry, all zeros when empty
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
//   count  out  clog2(DEPTH)+1  number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module bist_fail_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));

   // A pop on an empty FIFO is meaningless and is dropped. A push into a
   // full FIFO is only accepted when the head frees a slot in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // DEPTH is a power of two, so pointer increment wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Head is forced to zero when empty so stale storage never leaks out.
   assign dout  = empty ? '0 : mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/bist_fail_log.sv
// -----------------------------------------------------------------------------
// bist_fail_log
//
// Read-compare and fail-capture stage for the memory BIST controller.
// Registers each controller read (address + expected bit), compares the
// memory's read data one cycle later, reports the result on is_equal and
// logs every failing read into a small FIFO drained by diagnostics.
//
// Optional feature: define BIST_LOG_SYNDROME_EN to add the log_syn port and
// store the per-bit syndrome (rd_data ^ expected word) with each entry.
//
// Parameters:
//   AW         - address width
//   DW         - memory word width (expected word = data bit replicated DW x)
//   LOG_DEPTH  - fail-log entries, power of two, >= 2
//   CNT_W      - width of the saturating total-fail counter
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   read       in   controller read strobe; rd_data returns one cycle later
//   data       in   expected data bit, valid with read
//   addr       in   AW    read address, valid with read
//   rd_data    in   DW    memory read data, valid the cycle after read
//   clr        in   synchronous clear of log, fail counter and overflow
//   is_equal   out  0 only in the compare cycle of a mismatching read
//   log_valid  out  log non-empty, head entry presented
//   log_rd_en  in   consume head entry
//   log_addr   out  AW    head entry address (0 when empty)
//   log_exp    out  head entry expected bit (0 = r0 phase, 1 = r1 phase)
//   log_count  out  clog2(LOG_DEPTH)+1  entries held
//   overflow   out  sticky: a fail was dropped because the log was full
//   log_syn    out  DW    head entry syndrome (BIST_LOG_SYNDROME_EN only)
//   fail_cnt   out  CNT_W total mismatches since clr/rst, saturating
//
// Drain handshake: while log_valid=1 the head entry is stable on log_addr /
// log_exp (/ log_syn). A cycle with log_valid=1 and log_rd_en=1 consumes the
// head at the rising edge; log_rd_en with log_valid=0 has no effect.
// log_valid never depends combinationally on log_rd_en.
// -----------------------------------------------------------------------------
module bist_fail_log
   import bist_pkg::*;
#(
   parameter int AW        = 4,
   parameter int DW        = 8,
   parameter int LOG_DEPTH = 4,
   parameter int CNT_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          read,
   input  logic                          data,
   input  logic [AW-1:0]                 addr,
   input  logic [DW-1:0]                 rd_data,
   input  logic                          clr,
   output logic                          is_equal,
   output logic                          log_valid,
   input  logic                          log_rd_en,
   output logic [AW-1:0]                 log_addr,
   output logic                          log_exp,
   output logic [$clog2(LOG_DEPTH):0]    log_count,
   output logic                          overflow,
`ifdef BIST_LOG_SYNDROME_EN
   output logic [DW-1:0]                 log_syn,
`endif
   output logic [CNT_W-1:0]              fail_cnt
);

   localparam int EW      = entry_width(AW, DW);
   localparam int EXP_POS = exp_bit_pos(AW);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

   // Stage 1: registered read context
   logic          cmp_valid;
   logic          cmp_exp;
   logic [AW-1:0] cmp_addr;

   // Stage 2: compare and log control
   logic [DW-1:0] exp_word;
   logic          mismatch;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic          drop;
   logic [EW-1:0] entry;
   logic [EW-1:0] head;

   // clr also kills the pending compare so nothing from before the clear
   // can land in the freshly emptied log.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_valid <= 1'b0;
         cmp_exp   <= EXP_R0;
         cmp_addr  <= '0;
      end else if (clr) begin
         cmp_valid <= 1'b0;
      end else begin
         cmp_valid <= read;
         if (read) begin
            cmp_exp  <= data;
            cmp_addr <= addr;
         end
      end
   end

   assign exp_word = (cmp_exp == EXP_R1) ? {DW{1'b1}} : {DW{1'b0}};

   // is_equal defaults high whenever no compare is pending so the
   // controller's sticky fail flag cannot set on idle cycles.
   assign mismatch = cmp_valid & (rd_data != exp_word);
   assign is_equal = ~mismatch;

   // A mismatch landing in the clr cycle is neither logged nor counted.
   assign push = mismatch & ~clr;

   // Full log without a concurrent pop: entry is lost, remember that.
   assign drop = push & fifo_full & ~log_rd_en;

`ifdef BIST_LOG_SYNDROME_EN
   assign entry = {rd_data ^ exp_word, cmp_exp, cmp_addr};
`else
   assign entry = {cmp_exp, cmp_addr};
`endif

   bist_fail_fifo #(
      .W     (EW),
      .DEPTH (LOG_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push),
      .din   (entry),
      .pop   (log_rd_en),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (log_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         fail_cnt <= '0;
      end else if (clr) begin
         overflow <= 1'b0;
         fail_cnt <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end
         // Counts every mismatch, including dropped ones.
         if (push && (fail_cnt != CNT_MAX)) begin
            fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

   // Head fields; the FIFO already zeroes its head when empty.
   assign log_valid = ~fifo_empty;
   assign log_addr  = head[ADDR_LSB +: AW];
   assign log_exp   = head[EXP_POS];
`ifdef BIST_LOG_SYNDROME_EN
   assign log_syn   = head[syn_lsb(AW) +: DW];
`endif

endmodule

// File: tb/tb_bist_fail_log.sv
// -----------------------------------------------------------------------------
// tb_bist_fail_log
//
// Self-checking bench for bist_fail_log. A behavioural model keeps the
// pending read, a queue of logged entries, the fail total and the overflow
// flag, and is advanced once per clock from the same inputs driven to the DUT.
// Define BIST_LOG_SYNDROME_EN to also exercise log_syn.
// -----------------------------------------------------------------------------
module tb_bist_fail_log;

  localparam int AW        = 4;
  localparam int DW        = 8;
  localparam int LOG_DEPTH = 4;
  localparam int CNT_W     = 8;
  localparam int CW        = $clog2(LOG_DEPTH) + 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          read, data, clr, log_rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data;
  logic          is_equal, log_valid, log_exp, overflow;
  logic [AW-1:0] log_addr;
  logic [CW-1:0] log_count;
  logic [CNT_W-1:0] fail_cnt;
`ifdef BIST_LOG_SYNDROME_EN
  logic [DW-1:0] log_syn;
`endif

  bist_fail_log #(
    .AW(AW), .DW(DW), .LOG_DEPTH(LOG_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .data      (data),
    .addr      (addr),
    .rd_data   (rd_data),
    .clr       (clr),
    .is_equal  (is_equal),
    .log_valid (log_valid),
    .log_rd_en (log_rd_en),
    .log_addr  (log_addr),
    .log_exp   (log_exp),
    .log_count (log_count),
    .overflow  (overflow),
`ifdef BIST_LOG_SYNDROME_EN
    .log_syn   (log_syn),
`endif
    .fail_cnt  (fail_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Entry = {syndrome, expected bit, address}
  logic [AW+DW:0] exp_q[$];
  int             m_cnt;
  bit             m_ov;
  bit             pend_v;
  logic           pend_e;
  logic [AW-1:0]  pend_a;
  bit             m_mism;

  function automatic logic [DW-1:0] word_of(input logic e);
    return e ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  function automatic logic [DW-1:0] bad_word(input logic e);
    logic [DW-1:0] w;
    w = DW'($urandom);
    if (w == word_of(e)) w = w ^ DW'(1 << $urandom_range(0, DW-1));
    return w;
  endfunction

  function automatic logic [AW-1:0] m_head_addr();
    logic [AW+DW:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[AW-1:0];
  endfunction

  function automatic logic m_head_exp();
    logic [AW+DW:0] e;
    if (exp_q.size() == 0) return 1'b0;
    e = exp_q[0];
    return e[AW];
  endfunction

  function automatic logic [DW-1:0] m_head_syn();
    logic [AW+DW:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[AW+1 +: DW];
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_ov   = 0;
    pend_v = 0;
    pend_e = 1'b0;
    pend_a = '0;
    m_mism = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs just after the falling edge, then let the
  // combinational compare settle; outputs are sampled before the next rise.
  task automatic drive(input logic rd, input logic d, input logic [AW-1:0] a,
                       input logic [DW-1:0] rdd, input logic c, input logic pop);
    @(negedge clk);
    read = rd; data = d; addr = a; rd_data = rdd; clr = c; log_rd_en = pop;
    #1;
    m_mism = pend_v && (rdd != word_of(pend_e));
  endtask

  // Model what the coming rising edge does with the inputs now applied.
  task automatic advance();
    logic [AW+DW:0] e;
    if (clr) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ov   = 0;
      pend_v = 0;
    end else begin
      if (log_rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_mism) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        e = {rd_data ^ word_of(pend_e), pend_e, pend_a};
        if (exp_q.size() < LOG_DEPTH) exp_q.push_back(e);
        else m_ov = 1;
      end
      pend_v = read;
      if (read) begin
        pend_e = data;
        pend_a = addr;
      end
    end
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; read = 0; data = 0; addr = '0; rd_data = '0; clr = 0; log_rd_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({is_equal, log_valid, log_exp, overflow} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset.flags: got is_equal/log_valid/log_exp/overflow=%b want 1000",
               {is_equal, log_valid, log_exp, overflow});
    end
    tests_run++;
    if (log_addr !== '0 || log_count !== '0 || fail_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset.values: got addr=%0d count=%0d fail_cnt=%0d want 0/0/0",
               log_addr, log_count, fail_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_read();
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (is_equal !== 1'b1 || m_mism) begin
      tests_failed++;
      $display("FAIL clean.is_equal: got %b want 1", is_equal);
    end
    advance();
    idle_cycle();
    tests_run++;
    if (log_valid !== 1'b0 || fail_cnt !== CNT_W'(m_cnt)) begin
      tests_failed++;
      $display("FAIL clean.log: got log_valid=%b fail_cnt=%0d want 0/%0d", log_valid, fail_cnt, m_cnt);
    end
    advance();
  endtask

  task automatic test_single_fail();
    drive(1'b1, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, 8'hF7, 1'b0, 1'b0);
    tests_run++;
    if (is_equal !== !m_mism) begin
      tests_failed++;
      $display("FAIL single.is_equal_low: got %b want %b", is_equal, !m_mism);
    end
    advance();
    drive(1'b0, 1'b0, '0, 8'hF7, 1'b0, 1'b0);
    tests_run++;
    if (is_equal !== 1'b1) begin
      tests_failed++;
      $display("FAIL single.is_equal_one_cycle: got %b want 1", is_equal);
    end
    tests_run++;
    if (log_valid !== 1'b1 || log_addr !== m_head_addr() || log_exp !== m_head_exp()) begin
      tests_failed++;
      $display("FAIL single.head: got v=%b addr=%0d exp=%b want 1/%0d/%b",
               log_valid, log_addr, log_exp, m_head_addr(), m_head_exp());
    end
    tests_run++;
    if (fail_cnt !== CNT_W'(m_cnt) || log_count !== CW'(exp_q.size())) begin
      tests_failed++;
      $display("FAIL single.counts: got fail_cnt=%0d count=%0d want %0d/%0d",
               fail_cnt, log_count, m_cnt, exp_q.size());
    end
`ifdef BIST_LOG_SYNDROME_EN
    tests_run++;
    if (log_syn !== m_head_syn()) begin
      tests_failed++;
      $display("FAIL single.syn: got %h want %h", log_syn, m_head_syn());
    end
`endif
    advance();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1); advance();
    idle_cycle();
    tests_run++;
    if (log_valid !== 1'b0 || log_addr !== '0) begin
      tests_failed++;
      $display("FAIL single.pop: got v=%b addr=%0d want 0/0", log_valid, log_addr);
    end
    advance();
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); advance();
    for (int k = 0; k < 7; k++) begin
      drive(k < 6, 1'(k), AW'(k), pend_v ? bad_word(pend_e) : 8'h00, 1'b0, 1'b0);
      advance();
    end
    idle_cycle();
    tests_run++;
    if (overflow !== m_ov || !m_ov) begin
      tests_failed++;
      $display("FAIL overflow.flag: got %b want 1", overflow);
    end
    tests_run++;
    if (fail_cnt !== CNT_W'(m_cnt) || log_count !== CW'(exp_q.size())) begin
      tests_failed++;
      $display("FAIL overflow.counts: got fail_cnt=%0d count=%0d want %0d/%0d",
               fail_cnt, log_count, m_cnt, exp_q.size());
    end
    advance();
    for (int k = 0; k < LOG_DEPTH; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      tests_run++;
      if (log_valid !== 1'b1 || log_addr !== m_head_addr() || log_exp !== m_head_exp()) begin
        tests_failed++;
        $display("FAIL overflow.drain%0d: got v=%b addr=%0d exp=%b want 1/%0d/%b",
                 k, log_valid, log_addr, log_exp, m_head_addr(), m_head_exp());
      end
      advance();
    end
    idle_cycle();
    tests_run++;
    if (log_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow.empty: got log_valid=%b want 0", log_valid);
    end
    advance();
  endtask

  task automatic test_full_pop();
    logic [AW-1:0] addrs [5];
    addrs = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd9};
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); advance();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), addrs[k], pend_v ? bad_word(pend_e) : 8'h00, 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, '0, bad_word(pend_e), 1'b0, 1'b1);
    tests_run++;
    if (log_count !== CW'(LOG_DEPTH) || is_equal !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpop.pre: got count=%0d is_equal=%b want %0d/0", log_count, is_equal, LOG_DEPTH);
    end
    advance();
    idle_cycle();
    tests_run++;
    if (log_count !== CW'(exp_q.size()) || overflow !== 1'b0 || log_addr !== m_head_addr()) begin
      tests_failed++;
      $display("FAIL fullpop.post: got count=%0d ov=%b head=%0d want %0d/0/%0d",
               log_count, overflow, log_addr, exp_q.size(), m_head_addr());
    end
    advance();
    for (int k = 0; k < LOG_DEPTH; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      tests_run++;
      if (log_addr !== m_head_addr() || log_exp !== m_head_exp()) begin
        tests_failed++;
        $display("FAIL fullpop.drain%0d: got addr=%0d exp=%b want %0d/%b",
                 k, log_addr, log_exp, m_head_addr(), m_head_exp());
      end
      advance();
    end
  endtask

  task automatic test_saturation_clr();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0); advance();
    for (int k = 0; k < CNT_MAX + 5; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), pend_v ? bad_word(pend_e) : 8'h00, 1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, '0, word_of(pend_e), 1'b0, 1'b0); advance();
    idle_cycle();
    tests_run++;
    if (fail_cnt !== CNT_W'(m_cnt) || m_cnt != CNT_MAX) begin
      tests_failed++;
      $display("FAIL sat.fail_cnt: got %0d want %0d", fail_cnt, CNT_MAX);
    end
    advance();
    drive(1'b1, 1'b1, 4'd7, '0, 1'b0, 1'b0); advance();
    // failing compare of addr 7 lands in the clr cycle
    drive(1'b0, 1'b0, '0, bad_word(1'b1), 1'b1, 1'b0); advance();
    idle_cycle();
    tests_run++;
    if (fail_cnt !== '0 || log_count !== '0 || overflow !== 1'b0 || log_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr.state: got fail_cnt=%0d count=%0d ov=%b v=%b want 0/0/0/0",
               fail_cnt, log_count, overflow, log_valid);
    end
    advance();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 4'd2, '0, 1'b0, 1'b0); advance();
    drive(1'b1, 1'b1, 4'd4, bad_word(pend_e), 1'b0, 1'b0); advance();
    drive(1'b1, 1'b0, 4'd6, bad_word(pend_e), 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, bad_word(pend_e), 1'b0, 1'b0);
    tests_run++;
    if (log_count !== CW'(exp_q.size()) || is_equal !== !m_mism) begin
      tests_failed++;
      $display("FAIL arst.pre: got count=%0d is_equal=%b want %0d/%b",
               log_count, is_equal, exp_q.size(), !m_mism);
    end
    #1 rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (log_valid !== 1'b0 || log_count !== '0 || is_equal !== 1'b1 || fail_cnt !== '0) begin
      tests_failed++;
      $display("FAIL arst.immediate: got v=%b count=%0d is_equal=%b fail_cnt=%0d want 0/0/1/0",
               log_valid, log_count, is_equal, fail_cnt);
    end
    @(negedge clk);
    read = 0; rd_data = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'd1, '0, 1'b0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (is_equal !== !m_mism) begin
      tests_failed++;
      $display("FAIL arst.resume: got is_equal=%b want %b", is_equal, !m_mism);
    end
    advance();
  endtask

  task automatic test_random();
    logic rd, d, c, p;
    logic [AW-1:0] a;
    logic [DW-1:0] rdd;
    for (int n = 0; n < 600; n++) begin
      rd  = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      c   = ($urandom_range(0, 59) == 0);
      p   = ($urandom_range(0, 2) == 0);
      if (!pend_v) rdd = DW'($urandom);
      else if ($urandom_range(0, 1) == 1) rdd = bad_word(pend_e);
      else rdd = word_of(pend_e);
      drive(rd, d, a, rdd, c, p);
      tests_run++;
      if (is_equal !== !m_mism) begin
        tests_failed++;
        $display("FAIL rand%0d.is_equal: got %b want %b", n, is_equal, !m_mism);
      end
      tests_run++;
      if (log_valid !== (exp_q.size() != 0) || log_count !== CW'(exp_q.size())) begin
        tests_failed++;
        $display("FAIL rand%0d.occupancy: got v=%b count=%0d want %b/%0d",
                 n, log_valid, log_count, exp_q.size() != 0, exp_q.size());
      end
      tests_run++;
      if (log_addr !== m_head_addr() || log_exp !== m_head_exp()) begin
        tests_failed++;
        $display("FAIL rand%0d.head: got addr=%0d exp=%b want %0d/%b",
                 n, log_addr, log_exp, m_head_addr(), m_head_exp());
      end
`ifdef BIST_LOG_SYNDROME_EN
      tests_run++;
      if (log_syn !== m_head_syn()) begin
        tests_failed++;
        $display("FAIL rand%0d.syn: got %h want %h", n, log_syn, m_head_syn());
      end
`endif
      tests_run++;
      if (overflow !== m_ov || fail_cnt !== CNT_W'(m_cnt)) begin
        tests_failed++;
        $display("FAIL rand%0d.stats: got ov=%b fail_cnt=%0d want %b/%0d",
                 n, overflow, fail_cnt, m_ov, m_cnt);
      end
      advance();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_read();
    test_single_fail();
    test_overflow();
    test_full_pop();
    test_saturation_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
